// File: rtl/uart_rx_frame_checker.sv
// UART receive frame checker: validates start/parity/stop of each deserialised frame,
// buffers one checked frame behind a valid/ready handshake and keeps error statistics.
module uart_rx_frame_checker #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  frame_valid,
  input  logic                  start_bit,
  input  logic [DATA_WIDTH-1:0] raw_data,
  input  logic                  parity_bit,
  input  logic [1:0]            stop_bits,
  input  logic [1:0]            parity_type,
  input  logic                  two_stop,
  input  logic                  data_ready,
  input  logic                  clear_status,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [2:0]            error_flag,
  output logic                  break_det,
  output logic                  overrun,
  output logic [3:0]            error_sticky,
  output logic [CNT_WIDTH-1:0]  parity_err_cnt,
  output logic [CNT_WIDTH-1:0]  framing_err_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state, state_nxt;

  logic p_err_c, s_err_c, t_err_c, brk_c, accept_c, par_c;
  logic load_c, ovr_c;
  logic [3:0]           sticky_nxt;
  logic [CNT_WIDTH-1:0] pcnt_base, fcnt_base, pcnt_nxt, fcnt_nxt;

  // Frame field checks, meaningful only while frame_valid is high
  always_comb begin
    par_c    = ^raw_data ^ parity_bit;
    p_err_c  = 1'b0;
    if (parity_type == 2'b01) p_err_c = ~par_c;
    else if (parity_type == 2'b10) p_err_c = par_c;
    s_err_c  = start_bit;
    t_err_c  = ~stop_bits[0] | (two_stop & ~stop_bits[1]);
    brk_c    = ~start_bit & (raw_data == '0) & ~stop_bits[0];
    accept_c = frame_valid & ~brk_c;
  end

  // Buffer FSM next state; a reload only happens when the old frame is consumed
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    ovr_c     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept_c) begin
          state_nxt = FULL;
          load_c    = 1'b1;
        end
      end
      FULL: begin
        if (accept_c) begin
          if (data_ready) load_c = 1'b1;
          else            ovr_c  = 1'b1;
        end else if (data_ready && !frame_valid) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Status next values: clear first, then the same-cycle frame's errors on top
  always_comb begin
    sticky_nxt = clear_status ? 4'b0 : error_sticky;
    pcnt_base  = clear_status ? '0 : parity_err_cnt;
    fcnt_base  = clear_status ? '0 : framing_err_cnt;
    pcnt_nxt   = pcnt_base;
    fcnt_nxt   = fcnt_base;
    if (accept_c) begin
      sticky_nxt = sticky_nxt | {ovr_c, t_err_c, s_err_c, p_err_c};
      if (p_err_c && pcnt_base != CNT_MAX) pcnt_nxt = pcnt_base + CNT_WIDTH'(1);
      if ((s_err_c || t_err_c) && fcnt_base != CNT_MAX) fcnt_nxt = fcnt_base + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_out        <= '0;
      error_flag      <= 3'b0;
      data_valid      <= 1'b0;
      break_det       <= 1'b0;
      overrun         <= 1'b0;
      error_sticky    <= 4'b0;
      parity_err_cnt  <= '0;
      framing_err_cnt <= '0;
    end else begin
      if (load_c) begin
        data_out   <= raw_data;
        error_flag <= {t_err_c, s_err_c, p_err_c};
      end
      data_valid      <= (state_nxt == FULL);
      break_det       <= frame_valid & brk_c;
      overrun         <= ovr_c;
      error_sticky    <= sticky_nxt;
      parity_err_cnt  <= pcnt_nxt;
      framing_err_cnt <= fcnt_nxt;
    end
  end

endmodule
